register_file: RTL and testbench

//   Architectural GPR file at the consuming end of the MEM/WB writeback path.
//   - Accepts the registered dest address / write flag / write data from the
//     MEM->WB pipeline stage and commits them to a register array.
//   - Serves two independent read ports to the decode stage.
//   - Write-through bypass: same-cycle writeback data is visible to decode

---
 rtl/register_file_if.sv | 26 ++
 rtl/register_file.sv | 60 ++++++
 tb/tb_register_file.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Writeback and decode-read bundle for the GPR file.
// The master drives the write/read requests, and the slave returns the read data.
interface register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  re1;
    logic [ADDR_WIDTH-1:0] raddr1;
    logic [DATA_WIDTH-1:0] rdata1;
    logic                  re2;
    logic [ADDR_WIDTH-1:0] raddr2;
    logic [DATA_WIDTH-1:0] rdata2;

    modport master (
        output we, waddr, wdata, re1, raddr1, re2, raddr2,
        input  rdata1, rdata2
    );

    modport slave (
        input  we, waddr, wdata, re1, raddr1, re2, raddr2,
        output rdata1, rdata2
    );
endinterface

// File: rtl/register_file.sv
// Architectural GPR file: it has one writeback port and two combinational decode read ports.
// Index 0 always reads as zero, and a same-cycle write is forwarded to the readers.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input logic            clk,
    input logic            rst,
    register_file_if.slave rf
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  wr_en;

    assign wr_en = rf.we && (rf.waddr != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[rf.waddr] = rf.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reset, disable and $zero all win over the bypass.
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic                  rst_v,
        input logic                  re,
        input logic [ADDR_WIDTH-1:0] ra,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  wen,
        input logic [ADDR_WIDTH-1:0] wa,
        input logic [DATA_WIDTH-1:0] wd
    );
        if (rst_v || !re || (ra == '0)) begin
            return '0;
        end else if (wen && (wa == ra)) begin
            return wd;
        end else begin
            return stored;
        end
    endfunction

    assign rf.rdata1 = read_port(rst, rf.re1, rf.raddr1, regs_q[rf.raddr1],
                                 wr_en, rf.waddr, rf.wdata);
    assign rf.rdata2 = read_port(rst, rf.re2, rf.raddr2, regs_q[rf.raddr2],
                                 wr_en, rf.waddr, rf.wdata);

endmodule

// File: tb/tb_register_file.sv
// Directed and random checks of register_file read/write/bypass/reset behaviour.
module tb_register_file;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [31:0] model [32];

    register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf_if ();

    register_file #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .NUM_REGS  (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rf (rf_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 50)
                $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs are applied just after an edge and settle before checking.
    task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                         input logic [31:0] wd, input logic r1, input logic [4:0] a1,
                         input logic r2, input logic [4:0] a2);
        rst          = r;
        rf_if.we     = w;
        rf_if.waddr  = wa;
        rf_if.wdata  = wd;
        rf_if.re1    = r1;
        rf_if.raddr1 = a1;
        rf_if.re2    = r2;
        rf_if.raddr2 = a2;
        #3;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (rf_if.we && rf_if.waddr != 5'd0) begin
            model[rf_if.waddr] = rf_if.wdata;
        end
        #1;
    endtask

    function automatic logic [31:0] ref_read(input logic re, input logic [4:0] ra);
        if (rst || !re || ra == 5'd0) return 32'h0;
        if (rf_if.we && rf_if.waddr == ra) return rf_if.wdata;
        return model[ra];
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 32; i++) model[i] = '0;

        // Reset state
        drive(1, 0, 0, 0, 1, 5'd3, 1, 5'd4);
        check_eq("rst_p1", rf_if.rdata1, 32'h0);
        check_eq("rst_p2", rf_if.rdata2, 32'h0);
        tick();
        tick();

        // 1. Fill r1..r31, then reset clears everything
        for (int i = 1; i < 32; i++) begin
            drive(0, 1, 5'(i), 32'hFFFF_FFFF, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 1, 5'd31, 1, 5'd1);
        check_eq("fill_r31", rf_if.rdata1, 32'hFFFF_FFFF);
        check_eq("fill_r1", rf_if.rdata2, 32'hFFFF_FFFF);
        tick();
        drive(1, 1, 5'd1, 32'hFFFF_FFFF, 1, 5'd31, 1, 5'd1);
        check_eq("rst_force_p1", rf_if.rdata1, 32'h0);
        check_eq("rst_nobypass_p2", rf_if.rdata2, 32'h0);
        tick();
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 0, 1, 5'(i), 1, 5'(31 - i));
            check_eq("clr_p1", rf_if.rdata1, 32'h0);
            check_eq("clr_p2", rf_if.rdata2, 32'h0);
            tick();
        end

        // 2. $zero
        drive(0, 1, 5'd0, 32'hDEAD_BEEF, 1, 5'd0, 1, 5'd0);
        check_eq("zero_wcyc_p1", rf_if.rdata1, 32'h0);
        check_eq("zero_wcyc_p2", rf_if.rdata2, 32'h0);
        tick();
        drive(0, 0, 0, 0, 1, 5'd0, 0, 0);
        check_eq("zero_after", rf_if.rdata1, 32'h0);
        tick();

        // 3. Basic write then read on both ports
        drive(0, 1, 5'd5, 32'h1234_5678, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 5'd5, 1, 5'd5);
        check_eq("basic_p1", rf_if.rdata1, 32'h1234_5678);
        check_eq("basic_p2", rf_if.rdata2, 32'h1234_5678);
        tick();

        // 4. Bypass over an old value
        drive(0, 1, 5'd7, 32'h0000_0001, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 5'd7);
        check_eq("byp_old", rf_if.rdata2, 32'h0000_0001);
        tick();
        drive(0, 1, 5'd7, 32'hA5A5_A5A5, 1, 5'd7, 1, 5'd7);
        check_eq("byp_p2", rf_if.rdata2, 32'hA5A5_A5A5);
        check_eq("byp_p1", rf_if.rdata1, 32'hA5A5_A5A5);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 5'd7);
        check_eq("byp_after", rf_if.rdata2, 32'hA5A5_A5A5);
        tick();
        drive(0, 1, 5'd7, 32'h0BAD_F00D, 1, 5'd7, 1, 5'd5);
        check_eq("byp_one_port", rf_if.rdata1, 32'h0BAD_F00D);
        check_eq("byp_other_port", rf_if.rdata2, 32'h1234_5678);
        tick();
        drive(0, 1, 5'd7, 32'h0000_0077, 1, 5'd7, 0, 0);
        check_eq("b2b_bypass", rf_if.rdata1, 32'h0000_0077);
        tick();
        drive(0, 0, 0, 0, 1, 5'd7, 0, 0);
        check_eq("b2b_last_wins", rf_if.rdata1, 32'h0000_0077);
        tick();

        // 5. Read disable, then reset together with a write
        drive(0, 0, 0, 0, 0, 5'd5, 1, 5'd5);
        check_eq("re1_off", rf_if.rdata1, 32'h0);
        check_eq("re2_on", rf_if.rdata2, 32'h1234_5678);
        tick();
        drive(0, 1, 5'd5, 32'hCAFE_0000, 1, 5'd9, 0, 5'd5);
        check_eq("re2_off_bypass", rf_if.rdata2, 32'h0);
        tick();
        drive(1, 1, 5'd9, 32'h0000_0055, 0, 0, 1, 5'd9);
        check_eq("rst_wr_cyc", rf_if.rdata2, 32'h0);
        tick();
        drive(0, 0, 0, 0, 1, 5'd5, 1, 5'd9);
        check_eq("rst_wr_r5", rf_if.rdata1, 32'h0);
        check_eq("rst_wr_r9", rf_if.rdata2, 32'h0);
        tick();

        // 6. Random traffic against the reference model
        for (int c = 0; c < 10000; c++) begin
            logic        r;
            logic        w;
            logic [4:0]  wa;
            logic [4:0]  a1;
            logic [4:0]  a2;
            logic [31:0] wd;
            r  = ($urandom_range(0, 99) == 0);
            w  = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            drive(r, w, wa, wd, ($urandom_range(0, 7) != 0), a1,
                  ($urandom_range(0, 7) != 0), a2);
            check_eq("rand_p1", rf_if.rdata1, ref_read(rf_if.re1, rf_if.raddr1));
            check_eq("rand_p2", rf_if.rdata2, ref_read(rf_if.re2, rf_if.raddr2));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
